// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of one gate under test: drives a/b, waits SETTLE_CYCLES,
// samples y_in against the selected gate's expected value and reports pass/err_count/first_fail.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic       sel_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VEC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [2:0] G_NOT  = 3'd2;
  localparam logic [2:0] G_BAD  = 3'd7;

  logic [1:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       pass_q, pass_d, selerr_q, selerr_d;
  logic [2:0] err_q, err_d;
  logic [1:0] ff_q, ff_d;
  logic       mism, last_vec;

  function automatic logic exp_y(input logic [2:0] s, input logic a, input logic b);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  // NOT walks a over {0,1} with b parked at 0; the two-input gates walk {a,b} = idx.
  function automatic logic [1:0] vec_ab(input logic [2:0] s, input logic [1:0] i);
    return (s == G_NOT) ? {i[0], 1'b0} : i;
  endfunction

  assign mism     = (y_in != exp_y(sel_q, a_q, b_q));
  assign last_vec = (sel_q == G_NOT) ? (idx_q == 2'd1) : (idx_q == 2'd3);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    pass_d   = pass_q;
    selerr_d = selerr_q;
    err_d    = err_q;
    ff_d     = ff_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d  = gate_sel;
          err_d  = 3'd0;
          ff_d   = 2'd0;
          pass_d = 1'b0;
          if (gate_sel == G_BAD) begin
            selerr_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            selerr_d   = 1'b0;
            idx_d      = 2'd0;
            cnt_d      = 4'd0;
            {a_d, b_d} = 2'b00;
            state_d    = S_VEC;
          end
        end
      end
      S_VEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE) begin
          if (mism) begin
            err_d = err_q + 3'd1;
            if (err_q == 3'd0) ff_d = {a_q, b_q};
          end
          if (last_vec) begin
            state_d = S_DONE;
            pass_d  = (err_d == 3'd0);
          end else begin
            idx_d      = idx_q + 2'd1;
            cnt_d      = 4'd0;
            {a_d, b_d} = vec_ab(sel_q, idx_q + 2'd1);
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        {a_d, b_d} = 2'b00;
        idx_d      = 2'd0;
        cnt_d      = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'd0;
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      pass_q   <= 1'b0;
      selerr_q <= 1'b0;
      err_q    <= 3'd0;
      ff_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pass_q   <= pass_d;
      selerr_q <= selerr_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign sel_err    = selerr_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: a behavioural gate (or a tied/wrong one) closes the
// loop on a_out/b_out; expected results are hand-computed and popped on each done pulse.
module tb_gate_sweep_checker;
  localparam int SETTLE = 2;

  logic       clk = 0, rst = 1, start = 0, y_in;
  logic [2:0] gate_sel = 0;
  logic       a_out, b_out, busy, done, pass, sel_err;
  logic [2:0] err_count;
  logic [1:0] first_fail;

  gate_sweep_checker #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
    .a_out(a_out), .b_out(b_out), .y_in(y_in), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail(first_fail), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // gate under test: mode 0 = real gate g, 1 = tied 0, 2 = tied 1
  int         mode = 0;
  logic [2:0] g = 0;
  always_comb begin
    y_in = 1'b0;
    case (mode)
      1: y_in = 1'b0;
      2: y_in = 1'b1;
      default:
        case (g)
          3'd0: y_in = a_out & b_out;
          3'd1: y_in = a_out | b_out;
          3'd2: y_in = ~a_out;
          3'd3: y_in = ~(a_out & b_out);
          3'd4: y_in = ~(a_out | b_out);
          3'd5: y_in = a_out ^ b_out;
          3'd6: y_in = ~(a_out ^ b_out);
          default: y_in = 1'b0;
        endcase
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [1:0] ff;
    logic       sel_err;
    int         cyc;
    string      name;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_latency"}, cyc, e.cyc);
        chk({e.name, "_busy"}, int'(busy), 1);
        chk({e.name, "_pass"}, int'(pass), int'(e.pass));
        chk({e.name, "_err_count"}, int'(err_count), int'(e.err));
        chk({e.name, "_first_fail"}, int'(first_fail), int'(e.ff));
        chk({e.name, "_sel_err"}, int'(sel_err), int'(e.sel_err));
      end
    end
  end

  // pulse start for one cycle; the edge that samples it is E0, done expected lat cycles later
  task automatic issue(input string name, input logic [2:0] sel, input int lat,
                       input logic p, input logic [2:0] e, input logic [1:0] ff, input logic se);
    @(negedge clk);
    gate_sel = sel;
    start    = 1;
    q.push_back('{pass: p, err: e, ff: ff, sel_err: se, cyc: cyc + 1 + lat, name: name});
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk({name, "_done_timeout"}, 0, 1);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_ab"}, int'({a_out, b_out}), 0);
    chk({name, "_pass"}, int'(pass), 0);
    chk({name, "_err"}, int'(err_count), 0);
    chk({name, "_ff"}, int'(first_fail), 0);
    chk({name, "_selerr"}, int'(sel_err), 0);
  endtask

  localparam int L4 = 4 * (SETTLE + 1);
  localparam int L2 = 2 * (SETTLE + 1);

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 0;

    // AND with a correct gate, also tracing the stimulus sequence
    mode = 0; g = 3'd0;
    issue("and", 3'd0, L4, 1'b1, 3'd0, 2'd0, 1'b0);
    for (int k = 0; k < L4; k++) begin
      chk("and_vector", int'({a_out, b_out}), k / (SETTLE + 1));
      @(negedge clk);
    end
    drain("and");
    repeat (3) @(negedge clk);
    chk("and_pass_held", int'(pass), 1);
    chk("and_idle_busy", int'(busy), 0);

    // XOR with y tied 0: misses at 01 and 10
    mode = 1;
    issue("xor_tie0", 3'd5, L4, 1'b0, 3'd2, 2'b01, 1'b0);
    drain("xor_tie0");
    chk("xor_err_held", int'(err_count), 2);

    // NOT with a correct gate: only a=0,1 with b=0
    mode = 0; g = 3'd2;
    issue("not", 3'd2, L2, 1'b1, 3'd0, 2'd0, 1'b0);
    for (int k = 0; k < L2; k++) begin
      chk("not_vector", int'({a_out, b_out}), (k / (SETTLE + 1)) * 2);
      @(negedge clk);
    end
    drain("not");

    // invalid select: done in the cycle right after E0, no stimulus movement
    issue("bad_sel", 3'd7, 0, 1'b0, 3'd0, 2'd0, 1'b1);
    chk("bad_sel_ab", int'({a_out, b_out}), 0);
    @(negedge clk);
    chk("bad_sel_busy_one_cycle", int'(busy), 0);
    chk("bad_sel_held", int'(sel_err), 1);
    drain("bad_sel");

    // NAND with extra starts and a mid-sweep gate_sel change; sel_err clears
    mode = 0; g = 3'd3;
    issue("nand_restart", 3'd3, L4, 1'b1, 3'd0, 2'd0, 1'b0);
    for (int i = 1; i < L4 + 2; i++) begin
      start = (i == 3 || i == 7);
      if (i == 4) gate_sel = 3'd1;
      @(negedge clk);
    end
    start = 0;
    drain("nand_restart");

    // OR with y tied 0: misses at 01, 10, 11
    mode = 1;
    issue("or_tie0", 3'd1, L4, 1'b0, 3'd3, 2'b01, 1'b0);
    drain("or_tie0");

    // NOR checked against an OR gate: every vector misses, count reaches 4
    mode = 0; g = 3'd1;
    issue("nor_vs_or", 3'd4, L4, 1'b0, 3'd4, 2'b00, 1'b0);
    drain("nor_vs_or");

    // AND with y tied 1: misses at 00, 01, 10
    mode = 2;
    issue("and_tie1", 3'd0, L4, 1'b0, 3'd3, 2'b00, 1'b0);
    drain("and_tie1");

    // NOR interrupted by reset: no done, everything back to reset values
    mode = 0; g = 3'd4;
    issue("nor_aborted", 3'd4, L4, 1'b1, 3'd0, 2'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("nor_aborted_busy_before_rst", int'(busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    q.delete();
    chk_reset_vals("mid_rst");
    repeat (20) @(negedge clk);
    chk("mid_rst_no_done_idle", int'(busy), 0);

    issue("nor_clean", 3'd4, L4, 1'b1, 3'd0, 2'd0, 1'b0);
    drain("nor_clean");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
